// File: rtl/sig_noise_mixer_pkg.sv
// Shared DSP constants: default sample width, saturation limits and the 48 kHz divider step.
package sig_noise_mixer_pkg;

    localparam int          DSP_SAMP_WIDTH     = 24;
    localparam logic [15:0] DSP_PHASE_STEP_48K = 16'd1042;

    // Largest positive two's-complement value of width w, zero-extended to 64 bits.
    function automatic logic [63:0] dsp_sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of width w, sign-extended to 64 bits.
    function automatic logic [63:0] dsp_sat_min(input int w);
        return ~dsp_sat_max(w);
    endfunction

    localparam logic [DSP_SAMP_WIDTH-1:0] DSP_SAT_MAX = DSP_SAMP_WIDTH'(dsp_sat_max(DSP_SAMP_WIDTH));
    localparam logic [DSP_SAMP_WIDTH-1:0] DSP_SAT_MIN = DSP_SAMP_WIDTH'(dsp_sat_min(DSP_SAMP_WIDTH));

endpackage

// File: rtl/sig_noise_mixer_sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth; a write while full is ignored unless a pop happens on the same edge.
// Head entry is visible combinationally; rd_data reads zero while empty so stale entries never leak out.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           cnt;
    logic                  do_wr;
    logic                  do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DEPTH_CNT);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sig_noise_mixer.sv
// Sample-rate divider, signal+attenuated-noise saturating mixer and output buffer.
// Capture on tick edge T, buffer write on T+1; a full buffer with no pop drops the new sample.
module sig_noise_mixer
    import sig_noise_mixer_pkg::*;
#(
    parameter int SAMP_WIDTH = DSP_SAMP_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [15:0]           i_phase_step,
    input  logic [SAMP_WIDTH-1:0] i_sig,
    input  logic [SAMP_WIDTH-1:0] i_noise,
    input  logic [1:0]            i_noise_att,
    input  logic                  i_clr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SAMP_WIDTH-1:0] o_sample,
    output logic                  o_tick,
    output logic                  o_sat,
    output logic [15:0]           o_drop_cnt
);
    localparam logic [SAMP_WIDTH-1:0] SAT_MAX = SAMP_WIDTH'(dsp_sat_max(SAMP_WIDTH));
    localparam logic [SAMP_WIDTH-1:0] SAT_MIN = SAMP_WIDTH'(dsp_sat_min(SAMP_WIDTH));

    logic [15:0]                  div_cnt;
    logic                         s1_vld;
    logic signed [SAMP_WIDTH-1:0] s1_sig;
    logic signed [SAMP_WIDTH-1:0] s1_noise;
    logic signed [SAMP_WIDTH-1:0] noise_shr;
    logic [SAMP_WIDTH:0]          sum_ext;
    logic                         sum_ovf;
    logic [SAMP_WIDTH-1:0]        mix_dat;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_wr;
    logic                         fifo_rd;
    logic                         drop;

    // Count is allowed to run past a lowered terminal value; it wraps through 16'hFFFF.
    assign o_tick = i_en && !i_rst && (div_cnt == i_phase_step);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     div_cnt <= '0;
        else if (i_en) div_cnt <= o_tick ? 16'd0 : div_cnt + 16'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld   <= 1'b0;
            s1_sig   <= '0;
            s1_noise <= '0;
        end else begin
            s1_vld <= o_tick;
            if (o_tick) begin
                s1_sig   <= i_sig;
                s1_noise <= i_noise;
            end
        end
    end

    // Attenuation is taken live in stage 2, not captured with the sample.
    assign noise_shr = s1_noise >>> i_noise_att;
    assign sum_ext   = {s1_sig[SAMP_WIDTH-1], s1_sig} + {noise_shr[SAMP_WIDTH-1], noise_shr};
    assign sum_ovf   = sum_ext[SAMP_WIDTH] ^ sum_ext[SAMP_WIDTH-1];
    assign mix_dat   = !sum_ovf ? sum_ext[SAMP_WIDTH-1:0]
                                : (sum_ext[SAMP_WIDTH] ? SAT_MIN : SAT_MAX);

    assign o_valid = !fifo_empty;
    assign fifo_rd = o_valid && i_ready;
    assign fifo_wr = s1_vld && (!fifo_full || fifo_rd);
    assign drop    = s1_vld && fifo_full && !fifo_rd;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sat      <= 1'b0;
            o_drop_cnt <= '0;
        end else if (i_clr) begin
            o_sat      <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (s1_vld && sum_ovf) o_sat <= 1'b1;
            if (drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

    sync_fifo #(
        .DATA_WIDTH(SAMP_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_out_fifo (
        .clk    (i_clk),
        .rst    (i_rst),
        .wr_en  (fifo_wr),
        .wr_data(mix_dat),
        .rd_en  (fifo_rd),
        .rd_data(o_sample),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_sig_noise_mixer.sv
// Directed bench for sig_noise_mixer with a cycle model and output scoreboard.
module tb_sig_noise_mixer;
    localparam int W     = 24;
    localparam int DEPTH = 4;

    logic          i_clk;
    logic          i_rst;
    logic          i_en;
    logic [15:0]   i_phase_step;
    logic [W-1:0]  i_sig;
    logic [W-1:0]  i_noise;
    logic [1:0]    i_noise_att;
    logic          i_clr;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_sample;
    logic          o_tick;
    logic          o_sat;
    logic [15:0]   o_drop_cnt;

    int checks = 0;
    int errors = 0;

    sig_noise_mixer #(.SAMP_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_phase_step(i_phase_step),
        .i_sig       (i_sig),
        .i_noise     (i_noise),
        .i_noise_att (i_noise_att),
        .i_clr       (i_clr),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sample    (o_sample),
        .o_tick      (o_tick),
        .o_sat       (o_sat),
        .o_drop_cnt  (o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {saturated, mixed sample}.
    function automatic logic [W:0] mix_ref(input logic [W-1:0] s, input logic [W-1:0] n,
                                           input logic [1:0] a);
        longint      sv;
        longint      nv;
        longint      sum;
        logic        sat;
        logic [63:0] r;
        sv  = longint'($signed(s));
        nv  = longint'($signed(n)) >>> a;
        sum = sv + nv;
        sat = 1'b0;
        if (sum > 64'sd8388607) begin
            sum = 64'sd8388607;
            sat = 1'b1;
        end else if (sum < -64'sd8388608) begin
            sum = -64'sd8388608;
            sat = 1'b1;
        end
        r = sum;
        return {sat, r[W-1:0]};
    endfunction

    logic [15:0]  cnt_m;
    logic         tick_m;
    logic         s1_vld_m;
    logic [W-1:0] s1_sig_m;
    logic [W-1:0] s1_noise_m;
    logic         sat_m;
    logic [15:0]  drop_m;
    logic [W:0]   m_res;
    logic [W-1:0] sb[$];

    // Model predicts the next edge from inputs and outputs settled at the falling edge.
    always @(negedge i_clk) begin
        if (i_rst) begin
            cnt_m    = '0;
            s1_vld_m = 1'b0;
            sat_m    = 1'b0;
            drop_m   = '0;
            sb.delete();
            chk("rst_valid",  o_valid,    0);
            chk("rst_tick",   o_tick,     0);
            chk("rst_sample", o_sample,   0);
            chk("rst_sat",    o_sat,      0);
            chk("rst_drop",   o_drop_cnt, 0);
        end else begin
            tick_m = i_en && (cnt_m == i_phase_step);
            chk("tick",     o_tick,     tick_m);
            chk("valid",    o_valid,    sb.size() != 0);
            chk("sat",      o_sat,      sat_m);
            chk("drop_cnt", o_drop_cnt, drop_m);
            if (sb.size() != 0 && i_ready) begin
                chk("sample", o_sample, sb[0]);
                void'(sb.pop_front());
            end
            if (s1_vld_m) begin
                m_res = mix_ref(s1_sig_m, s1_noise_m, i_noise_att);
                if (m_res[W]) sat_m = 1'b1;
                if (sb.size() < DEPTH) sb.push_back(m_res[W-1:0]);
                else if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
            end
            if (i_clr) begin
                sat_m  = 1'b0;
                drop_m = '0;
            end
            s1_vld_m   = tick_m;
            s1_sig_m   = i_sig;
            s1_noise_m = i_noise;
            if (i_en) cnt_m = tick_m ? 16'd0 : cnt_m + 16'd1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_en  = 1'b0;
        step(1);
        i_rst = 1'b0;
    endtask

    initial begin
        int n;
        i_rst = 1'b1; i_en = 1'b0; i_phase_step = '0; i_sig = '0; i_noise = '0;
        i_noise_att = '0; i_clr = 1'b0; i_ready = 1'b1;
        step(3);
        chk("reset_valid",  o_valid,    0);
        chk("reset_tick",   o_tick,     0);
        chk("reset_sample", o_sample,   0);
        chk("reset_sat",    o_sat,      0);
        chk("reset_drop",   o_drop_cnt, 0);

        // Divider period 4, first tick on the 4th cycle after release; random mix data.
        i_rst = 1'b0; i_en = 1'b1; i_phase_step = 16'd3;
        for (int i = 0; i < 16; i++) begin
            i_sig       = W'($urandom);
            i_noise     = W'($urandom);
            i_noise_att = 2'($urandom_range(0, 3));
            #1 chk("tick_period", o_tick, (i % 4) == 3);
            step(1);
        end

        // Positive saturation, then clear.
        do_reset();
        i_ready = 1'b0; i_phase_step = 16'd0; i_sig = 24'h7FFFF0; i_noise = 24'h000100;
        i_noise_att = 2'd0; i_en = 1'b1;
        step(1); i_en = 1'b0;
        step(1);
        chk("pos_valid",  o_valid,  1);
        chk("pos_sample", o_sample, 24'h7FFFFF);
        chk("pos_sat",    o_sat,    1);
        i_clr = 1'b1; step(1); i_clr = 1'b0;
        chk("pos_clear",  o_sat,    0);
        i_ready = 1'b1; step(2);

        // Negative saturation through attenuated noise.
        i_ready = 1'b0; i_sig = 24'h800010; i_noise = 24'hFFFF00; i_noise_att = 2'd2; i_en = 1'b1;
        step(1); i_en = 1'b0;
        step(1);
        chk("neg_sample", o_sample, 24'h800000);
        chk("neg_sat",    o_sat,    1);
        i_clr = 1'b1; step(1); i_clr = 1'b0;
        // Clear lands on the same edge as another saturating write.
        i_en = 1'b1; step(1); i_en = 1'b0; i_clr = 1'b1; step(1); i_clr = 1'b0;
        chk("clr_wins_sat",   o_sat,   0);
        chk("clr_wins_valid", o_valid, 1);
        i_ready = 1'b1; step(3);

        // Six ticks into a stalled 4-entry buffer.
        do_reset();
        i_ready = 1'b0; i_phase_step = 16'd0; i_noise = '0; i_noise_att = 2'd0; i_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_sig = W'(16 * (i + 1));
            step(1);
        end
        i_en = 1'b0; step(3);
        chk("drop_cnt_two", o_drop_cnt, 2);
        chk("full_head",    o_sample,   24'h000010);
        // Pop and write on the same edge while full.
        i_sig = 24'h0ABCDE; i_en = 1'b1; step(1);
        i_en = 1'b0; i_ready = 1'b1; step(1);
        i_ready = 1'b0; step(1);
        chk("no_drop",       o_drop_cnt, 2);
        chk("head_after_pw", o_sample,   24'h000020);
        i_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid) n++;
            step(1);
        end
        chk("occupancy", n, 4);

        // Reset with three samples buffered.
        do_reset();
        i_ready = 1'b0; i_phase_step = 16'd0; i_sig = 24'h123456; i_noise = 24'h000010; i_en = 1'b1;
        step(3); i_en = 1'b0; step(2);
        chk("pre_rst_valid", o_valid, 1);
        i_rst = 1'b1;
        #1;
        chk("rst_async_valid",  o_valid,  0);
        chk("rst_async_sample", o_sample, 0);
        step(1);
        i_rst = 1'b0; i_ready = 1'b1; step(4);
        chk("no_stale", o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
